// File: rtl/loader_pkg.sv
// Shared types and constants for the UART-driven bus loader.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS_WR,
    BUS_RD,
    RD_WAIT,
    TX_LOAD,
    TX_WAIT
  } state_e;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] RSP_ACK   = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_ERR   = 8'h3F;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              we;
  } bus_req_t;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte timeout: load restarts the count, clear disarms, expired flags TIMEOUT_CYCLES-1 idle clocks.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int unsigned     CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             armed_q, armed_d;
  logic             expired_q, expired_d;

  always_comb begin
    count_d = count_q;
    armed_d = armed_q;
    if (clear) begin
      armed_d = 1'b0;
      count_d = '0;
    end else if (load) begin
      armed_d = 1'b1;
      count_d = '0;
    end else if (armed_q && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
    expired_d = armed_d && (count_d == LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      armed_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      armed_q   <= armed_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/uart_bus_loader.sv
// UART command loader: parses W/R byte commands, drives one bus access, and returns response bytes.
module uart_bus_loader
  import loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              rx_ack,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic              hold_cpu,
  output logic [WORD_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [WORD_W-1:0] bus_rdata
);

  localparam int unsigned      LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);
  localparam int unsigned      LOW_HI   = WORD_W - BYTE_W - 1;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              is_write_q, is_write_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  bus_req_t          bus_q, bus_d;
  logic [WORD_W-1:0] tx_buf_q, tx_buf_d;
  logic [1:0]        tx_left_q, tx_left_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_send_q, tx_send_d;
  logic              rx_ack_q, rx_ack_d;
  logic              hold_q, hold_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              seen_busy_q, seen_busy_d;
  logic [1:0]        wait_q, wait_d;

  logic consume_c;
  logic tx_done_c;
  logic tmo_load_c;
  logic tmo_clear_c;
  logic tmo_expired;

  // The cycle after an ack the receiver flag is still stale, so it is ignored then.
  assign consume_c = rx_ready && !rx_ack_q &&
                     ((state_q == IDLE) || (state_q == ADDR) || (state_q == DATA));

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .load    (tmo_load_c),
    .clear   (tmo_clear_c),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bus_d       = bus_q;
    bus_d.we    = 1'b0;
    tx_buf_d    = tx_buf_q;
    tx_left_d   = tx_left_q;
    tx_data_d   = tx_data_q;
    tx_send_d   = 1'b0;
    rx_ack_d    = consume_c;
    lat_d       = lat_q;
    seen_busy_d = seen_busy_q;
    wait_d      = wait_q;
    tx_done_c   = 1'b0;
    tmo_load_c  = 1'b0;
    tmo_clear_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (consume_c) begin
          if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
            is_write_d = (rx_data == CMD_WRITE);
            cnt_d      = 2'd0;
            tmo_load_c = 1'b1;
            state_d    = ADDR;
          end else begin
            tx_buf_d  = {RSP_ERR, (WORD_W - BYTE_W)'(0)};
            tx_left_d = 2'd0;
            state_d   = TX_LOAD;
          end
        end
      end

      ADDR: begin
        if (consume_c) begin
          addr_d = {addr_q[LOW_HI:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_write_q) begin
              tmo_load_c = 1'b1;
              state_d    = DATA;
            end else begin
              tmo_clear_c = 1'b1;
              bus_d.addr  = {addr_q[LOW_HI:0], rx_data};
              state_d     = BUS_RD;
            end
          end else begin
            tmo_load_c = 1'b1;
          end
        end else if (tmo_expired) begin
          tmo_clear_c = 1'b1;
          cnt_d       = 2'd0;
          state_d     = IDLE;
        end
      end

      DATA: begin
        if (consume_c) begin
          wdata_d = {wdata_q[LOW_HI:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Load the bus registers on entry so the strobe lines up with BUS_WR.
            tmo_clear_c = 1'b1;
            bus_d.addr  = addr_q;
            bus_d.wdata = {wdata_q[LOW_HI:0], rx_data};
            bus_d.we    = 1'b1;
            state_d     = BUS_WR;
          end else begin
            tmo_load_c = 1'b1;
          end
        end else if (tmo_expired) begin
          tmo_clear_c = 1'b1;
          cnt_d       = 2'd0;
          state_d     = IDLE;
        end
      end

      BUS_WR: begin
        tx_buf_d  = {RSP_ACK, (WORD_W - BYTE_W)'(0)};
        tx_left_d = 2'd0;
        state_d   = TX_LOAD;
      end

      BUS_RD: begin
        lat_d   = '0;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          tx_buf_d  = bus_rdata;
          tx_left_d = 2'd3;
          state_d   = TX_LOAD;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      TX_LOAD: begin
        if (!tx_busy) begin
          tx_data_d   = tx_buf_q[WORD_W-1 -: BYTE_W];
          tx_buf_d    = {tx_buf_q[LOW_HI:0], BYTE_W'(0)};
          tx_send_d   = 1'b1;
          seen_busy_d = 1'b0;
          wait_d      = 2'd0;
          state_d     = TX_WAIT;
        end
      end

      TX_WAIT: begin
        // A transmitter that never raises busy within four cycles is taken as done.
        if (seen_busy_q) begin
          tx_done_c = !tx_busy;
        end else if (tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (wait_q == 2'd3) begin
          tx_done_c = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
        if (tx_done_c) begin
          if (tx_left_q != 2'd0) begin
            tx_left_d = tx_left_q - 2'd1;
            state_d   = TX_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    hold_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_q       <= '0;
      tx_buf_q    <= '0;
      tx_left_q   <= 2'd0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      rx_ack_q    <= 1'b0;
      hold_q      <= 1'b0;
      lat_q       <= '0;
      seen_busy_q <= 1'b0;
      wait_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_q       <= bus_d;
      tx_buf_q    <= tx_buf_d;
      tx_left_q   <= tx_left_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      rx_ack_q    <= rx_ack_d;
      hold_q      <= hold_d;
      lat_q       <= lat_d;
      seen_busy_q <= seen_busy_d;
      wait_q      <= wait_d;
    end
  end

  assign rx_ack    = rx_ack_q;
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign hold_cpu  = hold_q;
  assign bus_addr  = bus_q.addr;
  assign bus_wdata = bus_q.wdata;
  assign bus_we    = bus_q.we;

endmodule

// File: tb/tb_uart_bus_loader.sv
// Randomized bench for uart_bus_loader with receiver, transmitter and bus memory models.
module tb_uart_bus_loader;

  localparam int unsigned TMO = 40;
  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic        hold_cpu;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;

  uart_bus_loader #(.TIMEOUT_CYCLES(TMO), .RD_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .hold_cpu(hold_cpu),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  int ack_cnt, ack_double, ack_spurious, send_busy, hold_gap;
  bit prev_ack;
  int rise_in;
  int busy_left;
  bit tx_silent;
  logic [31:0] last_addr;
  int stable;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
  endfunction

  task automatic drive_inputs();
    rx_ready = (rx_q.size() > 0);
    rx_data  = rx_ready ? rx_q[0] : 8'($urandom());
  endtask

  task automatic clear_log();
    tx_q.delete(); wa_q.delete(); wd_q.delete();
    exp_tx.delete(); exp_wa.delete(); exp_wd.delete();
    ack_cnt = 0; ack_double = 0; ack_spurious = 0; send_busy = 0; hold_gap = 0;
  endtask

  // One clock of environment: observe DUT outputs after the edge, then update models.
  task automatic tick();
    @(posedge clock); #1;
    if (rx_ack) begin
      ack_cnt++;
      if (prev_ack) ack_double++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      else ack_spurious++;
    end
    prev_ack = rx_ack;
    if (ack_cnt > 0 && rx_q.size() > 0 && !hold_cpu) hold_gap++;
    if (bus_we) begin
      wa_q.push_back(bus_addr);
      wd_q.push_back(bus_wdata);
    end
    if (tx_send) begin
      tx_q.push_back(tx_data);
      if (tx_busy) send_busy++;
      if (!tx_silent) begin
        rise_in   = $urandom_range(0, 2);
        busy_left = $urandom_range(2, 6);
      end
    end
    if (rise_in == 0) begin
      tx_busy = 1'b1;
      rise_in = -1;
    end else if (rise_in > 0) begin
      rise_in--;
    end else if (tx_busy) begin
      busy_left--;
      if (busy_left <= 0) tx_busy = 1'b0;
    end
    if (bus_addr !== last_addr) stable = 0;
    else stable++;
    last_addr = bus_addr;
    bus_rdata = (stable >= int'(LAT)) ? mem_fn(bus_addr) : $urandom();
    drive_inputs();
  endtask

  task automatic model_cmd(input logic [7:0] c[$]);
    logic [31:0] a, d;
    if (c[0] == 8'h57 || c[0] == 8'h52) begin
      a = {c[1], c[2], c[3], c[4]};
      if (c[0] == 8'h57) begin
        d = {c[5], c[6], c[7], c[8]};
        exp_wa.push_back(a);
        exp_wd.push_back(d);
        exp_tx.push_back(8'h4B);
      end else begin
        d = mem_fn(a);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
      end
    end else begin
      exp_tx.push_back(8'h3F);
    end
  endtask

  // kind 0 = write, 1 = read, 2 = unknown command byte
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] c[$];
    logic [7:0] u;
    if (kind == 2) begin
      u = d[7:0];
      if (u == 8'h57 || u == 8'h52) u = 8'h41;
      c.push_back(u);
    end else begin
      c.push_back(kind == 0 ? 8'h57 : 8'h52);
      for (int i = 3; i >= 0; i--) c.push_back(a[i*8 +: 8]);
      if (kind == 0) for (int i = 3; i >= 0; i--) c.push_back(d[i*8 +: 8]);
    end
    model_cmd(c);
    foreach (c[i]) rx_q.push_back(c[i]);
    drive_inputs();
  endtask

  task automatic run_cmds(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (ack_cnt > 0 && rx_q.size() == 0 && !hold_cpu && !tx_busy && rise_in < 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (rx_ack !== 1'b0)    begin failures++; $display("FAIL reset_rx_ack got=%b want=0", rx_ack); end
    checks++; if (tx_send !== 1'b0)   begin failures++; $display("FAIL reset_tx_send got=%b want=0", tx_send); end
    checks++; if (tx_data !== 8'h00)  begin failures++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    checks++; if (bus_we !== 1'b0)    begin failures++; $display("FAIL reset_bus_we got=%b want=0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL reset_bus_addr got=%h want=0", bus_addr); end
    checks++; if (bus_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus_wdata got=%h want=0", bus_wdata); end
    checks++; if (hold_cpu !== 1'b0)  begin failures++; $display("FAIL reset_hold_cpu got=%b want=0", hold_cpu); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    bit ok;
    clear_log();
    issue(0, 32'h0000_0010, 32'hDEAD_BEEF);
    run_cmds(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL write_done got=timeout want=idle"); end
    checks++; if (ack_cnt != 9 || ack_double != 0 || ack_spurious != 0) begin
      failures++; $display("FAIL write_acks got=%0d dbl=%0d spur=%0d want=9/0/0", ack_cnt, ack_double, ack_spurious);
    end
    checks++; if (wa_q.size() != 1) begin failures++; $display("FAIL write_pulses got=%0d want=1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 32'h0000_0010) begin failures++; $display("FAIL write_addr got=%h want=00000010", wa_q[0]); end
      checks++; if (wd_q[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL write_data got=%h want=deadbeef", wd_q[0]); end
    end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
      failures++; $display("FAIL write_resp got_n=%0d want=1 byte 4b", tx_q.size());
    end
    checks++; if (hold_gap != 0) begin failures++; $display("FAIL write_hold got_gaps=%0d want=0", hold_gap); end
  endtask

  task automatic test_read();
    bit ok;
    logic [7:0] want[4];
    want[0] = 8'h12; want[1] = 8'h34; want[2] = 8'h56; want[3] = 8'h78;
    clear_log();
    issue(1, 32'h0000_0010, 32'h0);
    run_cmds(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL read_done got=timeout want=idle"); end
    checks++; if (tx_q.size() != 4) begin failures++; $display("FAIL read_count got=%0d want=4", tx_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (tx_q[i] !== want[i]) begin failures++; $display("FAIL read_byte%0d got=%h want=%h", i, tx_q[i], want[i]); end
    end
    checks++; if (send_busy != 0) begin failures++; $display("FAIL read_send_busy got=%0d want=0", send_busy); end
    checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL read_bus_we got=%0d want=0", wa_q.size()); end
  endtask

  task automatic test_unknown();
    bit ok;
    clear_log();
    issue(2, 32'h0, 32'h41);
    run_cmds(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL unk_done got=timeout want=idle"); end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h3F) begin failures++; $display("FAIL unk_resp got_n=%0d want=1 byte 3f", tx_q.size()); end
    checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL unk_bus_we got=%0d want=0", wa_q.size()); end
  endtask

  task automatic test_tx_silent();
    bit seen = 1'b0;
    clear_log();
    tx_silent = 1'b1;
    issue(2, 32'h0, 32'h00);
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      seen = (tx_q.size() > 0);
    end
    checks++; if (!seen) begin failures++; $display("FAIL silent_send got=none want=send"); end
    repeat (3) tick();
    checks++; if (hold_cpu !== 1'b1) begin failures++; $display("FAIL silent_hold_early got=%b want=1", hold_cpu); end
    tick();
    checks++; if (hold_cpu !== 1'b0) begin failures++; $display("FAIL silent_hold_release got=%b want=0", hold_cpu); end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h3F) begin failures++; $display("FAIL silent_resp got_n=%0d want=1 byte 3f", tx_q.size()); end
    tx_silent = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    logic [31:0] a;
    logic [7:0] c[$];
    clear_log();
    c = '{8'h57, 8'h00, 8'h00};
    foreach (c[i]) rx_q.push_back(c[i]);
    drive_inputs();
    for (int n = 0; n < 100 && rx_q.size() > 0; n++) tick();
    repeat (TMO - 2) tick();
    checks++; if (hold_cpu !== 1'b1) begin failures++; $display("FAIL tmo_early got=%b want=1", hold_cpu); end
    repeat (4) tick();
    checks++; if (hold_cpu !== 1'b0) begin failures++; $display("FAIL tmo_expire got=%b want=0", hold_cpu); end
    checks++; if (tx_q.size() != 0 || wa_q.size() != 0) begin
      failures++; $display("FAIL tmo_side_effects got_tx=%0d got_we=%0d want=0/0", tx_q.size(), wa_q.size());
    end
    clear_log();
    a = $urandom();
    issue(1, a, 32'h0);
    run_cmds(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_read_done got=timeout want=idle"); end
    checks++; if (tx_q.size() != exp_tx.size()) begin failures++; $display("FAIL tmo_read_count got=%0d want=%0d", tx_q.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin
      checks++; if (tx_q[i] !== exp_tx[i]) begin failures++; $display("FAIL tmo_read_byte%0d got=%h want=%h", i, tx_q[i], exp_tx[i]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int v = 0; v < 2; v++) begin
      clear_log();
      issue(1, $urandom(), 32'h0);
      for (int n = 0; n < 100 && rx_q.size() > 0; n++) tick();
      if (v == 1) for (int n = 0; n < 200 && tx_q.size() < 2; n++) tick();
      reset = 1'b1;
      rx_q.delete();
      drive_inputs();
      tick();
      checks++; if ({rx_ack, tx_send, bus_we, hold_cpu} !== 4'b0 || tx_data !== 8'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
        failures++; $display("FAIL rstmid%0d_outputs got=%b%b%b%b %h %h %h want=all zero", v, rx_ack, tx_send, bus_we, hold_cpu, tx_data, bus_addr, bus_wdata);
      end
      reset = 1'b0;
      tx_busy = 1'b0;
      rise_in = -1;
      repeat (10) tick();
      checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL rstmid%0d_bus_we got=%0d want=0", v, wa_q.size()); end
      checks++; if (hold_cpu !== 1'b0 || tx_q.size() != v * 2) begin
        failures++; $display("FAIL rstmid%0d_quiet got_hold=%b got_tx=%0d want=0/%0d", v, hold_cpu, tx_q.size(), v * 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    issue(1, $urandom(), 32'h0);
    issue(0, $urandom(), $urandom());
    issue(2, 32'h0, $urandom());
    run_cmds(5000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done got=timeout want=idle"); end
    checks++; if (ack_cnt != 15 || ack_double != 0) begin failures++; $display("FAIL b2b_acks got=%0d dbl=%0d want=15/0", ack_cnt, ack_double); end
    checks++; if (tx_q.size() != exp_tx.size()) begin failures++; $display("FAIL b2b_tx_count got=%0d want=%0d", tx_q.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin
      checks++; if (tx_q[i] !== exp_tx[i]) begin failures++; $display("FAIL b2b_tx%0d got=%h want=%h", i, tx_q[i], exp_tx[i]); end
    end
    checks++; if (wa_q.size() != 1 || wa_q[0] !== exp_wa[0] || wd_q[0] !== exp_wd[0]) begin
      failures++; $display("FAIL b2b_write got_n=%0d want addr=%h data=%h", wa_q.size(), exp_wa[0], exp_wd[0]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int kind;
    for (int it = 0; it < 12; it++) begin
      clear_log();
      kind = $urandom_range(0, 2);
      issue(kind, $urandom(), $urandom());
      run_cmds(3000, ok);
      checks++; if (!ok || ack_double != 0 || send_busy != 0 || hold_gap != 0) begin
        failures++; $display("FAIL rand%0d_flow got ok=%0d dbl=%0d sb=%0d gap=%0d want=1/0/0/0", it, ok, ack_double, send_busy, hold_gap);
      end
      checks++; if (tx_q.size() != exp_tx.size()) begin failures++; $display("FAIL rand%0d_tx_count got=%0d want=%0d", it, tx_q.size(), exp_tx.size()); end
      else foreach (exp_tx[i]) begin
        checks++; if (tx_q[i] !== exp_tx[i]) begin failures++; $display("FAIL rand%0d_tx%0d got=%h want=%h", it, i, tx_q[i], exp_tx[i]); end
      end
      checks++; if (wa_q.size() != exp_wa.size()) begin failures++; $display("FAIL rand%0d_we_count got=%0d want=%0d", it, wa_q.size(), exp_wa.size()); end
      else foreach (exp_wa[i]) begin
        checks++; if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) begin
          failures++; $display("FAIL rand%0d_write got=%h/%h want=%h/%h", it, wa_q[i], wd_q[i], exp_wa[i], exp_wd[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    tx_busy = 1'b0;
    bus_rdata = 32'h0;
    rise_in = -1;
    busy_left = 0;
    tx_silent = 1'b0;
    prev_ack = 1'b0;
    last_addr = 32'h0;
    stable = 0;
    rx_q.delete();
    clear_log();
    drive_inputs();
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_tx_silent();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=no_finish want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_bus_loader.md
UART_BUS_LOADER -- requirements
Module: uart_bus_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: idle clock count between received bytes that aborts a command.
REQ-002 Parameter RD_LATENCY, default 1: clocks from the bus_addr drive to valid bus_rdata.
REQ-003 clock  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  received byte from the UART receiver.
REQ-006 rx_ready  in  1  level; rx_data valid until acknowledged.
REQ-007 rx_ack  out  1  one-cycle pulse; clears receiver ready flag.
REQ-008 tx_data  out  8  byte to transmit.
REQ-009 tx_send  out  1  one-cycle pulse; starts transmission.
REQ-010 tx_busy  in  1  transmitter busy level.
REQ-011 hold_cpu  out  1  high whenever not IDLE; stalls the core and grants the bus to this block.
REQ-012 bus_addr  out  32  bus address.
REQ-013 bus_wdata  out  32  bus write data.
REQ-014 bus_we  out  1  one-cycle write strobe.
REQ-015 bus_rdata  in  32  bus read data.

Function
REQ-016 The FSM SHALL have these states: IDLE, ADDR, DATA, BUS_WR, BUS_RD, RD_WAIT, TX_LOAD, TX_WAIT.
REQ-017 A byte SHALL be consumed only when rx_ready=1 in a state that expects a byte; rx_ack pulses that cycle; rx_ready is ignored the following cycle.
REQ-018 In IDLE, 0x57 'W' or 0x52 'R' SHALL go to ADDR with byte count 0; any other byte SHALL queue response 0x3F and go to TX_LOAD.
REQ-019 ADDR SHALL shift 4 bytes, MSB first, into the address register; after the 4th byte, 'W' goes to DATA and 'R' goes to BUS_RD.
REQ-020 DATA SHALL shift 4 bytes, MSB first, into the write-data register and then go to BUS_WR.
REQ-021 BUS_WR SHALL assert bus_we for exactly one cycle with bus_addr/bus_wdata stable, queue response 0x4B, and go to TX_LOAD.
REQ-022 BUS_RD SHALL drive bus_addr, wait RD_LATENCY cycles in RD_WAIT, capture bus_rdata, queue its 4 bytes MSB first, and go to TX_LOAD.
REQ-023 TX_LOAD SHALL wait for tx_busy=0, then pulse tx_send with tx_data stable, and go to TX_WAIT.
REQ-024 TX_WAIT SHALL wait for tx_busy=1 followed by tx_busy=0; then send the next queued byte or, if none remains, go to IDLE.
REQ-025 In ADDR/DATA, the timeout counter SHALL reset on each consumed byte; reaching TIMEOUT_CYCLES-1 SHALL return the FSM to IDLE with no response and no bus access.
REQ-026 In TX_WAIT, if tx_busy does not rise within 4 cycles, the byte SHALL be treated as sent.
REQ-027 The byte counter SHALL be 2 bits and wrap 3->0 on the transition out of ADDR/DATA.
REQ-028 bytes arriving during BUS_*/RD_WAIT/TX_* SHALL NOT be acknowledged; they remain pending until IDLE.
REQ-029 bus_addr and bus_wdata SHALL hold their last values outside bus states; bus_we=0 outside BUS_WR.

Reset
REQ-030 Reset SHALL force IDLE, clear counters and registers, and drive rx_ack=0, tx_send=0, tx_data=0, bus_we=0, bus_addr=0, bus_wdata=0, hold_cpu=0 on the next edge.
REQ-031 Reset mid-command or mid-transmission SHALL discard all state; no bus write SHALL occur in the reset cycle or after it.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum, the command constants 0x57/0x52, and the response constants 0x4B/0x3F.
REQ-033 The inter-byte timeout counter SHALL be a sub-module loader_timeout with load, clear, and expired ports.
REQ-034 The RTL SHALL be 120-400 lines and contain no latches.

Verification
REQ-035 Write: 'W',00,00,00,10,DE,AD,BE,EF -> one bus_we pulse with addr 0x00000010, data 0xDEADBEEF; TX 0x4B; hold_cpu high throughout.
REQ-036 Read: 'R',00,00,00,10 with bus_rdata=0x12345678 after RD_LATENCY -> TX 12,34,56,78 in order, each tx_send issued only after tx_busy falls.
REQ-037 Unknown command 0x41 -> TX 0x3F, no bus access, return to IDLE.
REQ-038 'W',00,00 then silence for TIMEOUT_CYCLES -> IDLE, no TX, no bus_we; a subsequent valid read completes correctly.
REQ-039 Reset asserted during BUS_RD/TX_WAIT of a read -> all outputs 0 next edge; bus_we never asserted.
REQ-040 rx_ready held high continuously for two bytes -> exactly one rx_ack per byte, none in the cycle immediately after an ack.
